// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - decodes a multiplexed 7-segment clock display into BCD time
// Samples each settled digit strobe, assembles frames and publishes only after repeated agreement.
module seg_scan_decoder #(
    parameter int SETTLE_CYC = 4,
    parameter int STABLE_N   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic [5:0]  dig_en,
    output logic [23:0] time_bcd,
    output logic        frame_valid,
    output logic        code_err,
    output logic        locked
);
    localparam logic [3:0] SETTLE_V = 4'(SETTLE_CYC);
    localparam logic [2:0] STABLE_V = 3'(STABLE_N);

    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1011111: r = {1'b1, 4'd0};
            7'b0000011: r = {1'b1, 4'd1};
            7'b1110110: r = {1'b1, 4'd2};
            7'b1110011: r = {1'b1, 4'd3};
            7'b0101011: r = {1'b1, 4'd4};
            7'b1111001: r = {1'b1, 4'd5};
            7'b1111101: r = {1'b1, 4'd6};
            7'b1000011: r = {1'b1, 4'd7};
            7'b1111111: r = {1'b1, 4'd8};
            7'b1101011: r = {1'b1, 4'd9};
            default:    r = 5'd0;
        endcase
        return r;
    endfunction

    logic [5:0]  dig_q, dig_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [23:0] shadow_q, shadow_d;
    logic [23:0] prev_q, prev_d;
    logic [5:0]  seen_q, seen_d;
    logic [2:0]  match_q, match_d;
    logic [23:0] time_q, time_d;
    logic        fv_q, fv_d;
    logic        err_q, err_d;
    logic        locked_q, locked_d;

    logic        strobe_stable;
    logic        strobe_onehot;
    logic        sample;
    logic [4:0]  dec;
    logic        frame_bad;
    logic        same_frame;

    always_comb begin
        dig_d         = dig_en;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        prev_d        = prev_q;
        seen_d        = seen_q;
        match_d       = match_q;
        time_d        = time_q;
        fv_d          = 1'b0;
        err_d         = 1'b0;
        locked_d      = locked_q;

        strobe_stable = (dig_en == dig_q);
        strobe_onehot = (dig_en != 6'd0) && ((dig_en & (dig_en - 6'd1)) == 6'd0);
        dec           = decode_seg(seg_in);
        same_frame    = (shadow_q == prev_q);
        frame_bad     = (shadow_q[23:20] > 4'd2)
                     || ((shadow_q[23:20] == 4'd2) && (shadow_q[19:16] > 4'd3))
                     || (shadow_q[15:12] > 4'd5)
                     || (shadow_q[7:4] > 4'd5);

        if (!strobe_stable) begin
            cnt_d = 4'd0;
        end else if (cnt_q != SETTLE_V) begin
            cnt_d = cnt_q + 4'd1;
        end

        // The sample fires on the edge that carries the counter into saturation,
        // so each unchanged strobe window yields at most one sample.
        sample = strobe_stable && strobe_onehot && (cnt_q == SETTLE_V - 4'd1);

        if (sample) begin
            if (dec[4]) begin
                for (int k = 0; k < 6; k++) begin
                    if (dig_en[k]) begin
                        shadow_d[4*k +: 4] = dec[3:0];
                    end
                end
                seen_d = seen_q | dig_en;
            end else begin
                err_d    = 1'b1;
                shadow_d = 24'd0;
                seen_d   = 6'd0;
                match_d  = 3'd0;
            end
        end else if (seen_q == 6'h3f) begin
            seen_d = 6'd0;
            if (frame_bad) begin
                err_d    = 1'b1;
                shadow_d = 24'd0;
                match_d  = 3'd0;
            end else begin
                if ((STABLE_N == 1) || same_frame) begin
                    match_d = (match_q == STABLE_V) ? STABLE_V : match_q + 3'd1;
                end else begin
                    match_d = 3'd1;
                end
                prev_d = shadow_q;
                // A saturated count only republishes when the content actually changed.
                if ((match_d == STABLE_V) && ((match_q != STABLE_V) || !same_frame)) begin
                    time_d   = shadow_q;
                    fv_d     = 1'b1;
                    locked_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q    <= 6'd0;
            cnt_q    <= 4'd0;
            shadow_q <= 24'd0;
            prev_q   <= 24'd0;
            seen_q   <= 6'd0;
            match_q  <= 3'd0;
            time_q   <= 24'd0;
            fv_q     <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            dig_q    <= dig_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            prev_q   <= prev_d;
            seen_q   <= seen_d;
            match_q  <= match_d;
            time_q   <= time_d;
            fv_q     <= fv_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

    assign time_bcd    = time_q;
    assign frame_valid = fv_q;
    assign code_err    = err_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder
// Strobe stimulus feeds a frame-level reference model; a monitor pops expected events.
module tb_seg_scan_decoder;
    localparam int SETTLE = 4;
    localparam int STABLE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_in = 7'd0;
    logic [5:0]  dig_en = 6'd0;
    logic [23:0] time_bcd;
    logic        frame_valid;
    logic        code_err;
    logic        locked;

    seg_scan_decoder #(.SETTLE_CYC(SETTLE), .STABLE_N(STABLE)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_en(dig_en),
        .time_bcd(time_bcd), .frame_valid(frame_valid), .code_err(code_err), .locked(locked)
    );

    always #5 clk = ~clk;

    logic [6:0] pat [0:9] = '{7'b1011111, 7'b0000011, 7'b1110110, 7'b1110011, 7'b0101011,
                              7'b1111001, 7'b1111101, 7'b1000011, 7'b1111111, 7'b1101011};

    typedef struct {
        bit          is_err;
        logic [23:0] t;
    } ev_t;
    ev_t exp_q[$];

    int vectors = 0;
    int miscompares = 0;
    int fv_seen = 0;
    int err_seen = 0;

    int          m_sh [6];
    logic [5:0]  m_seen;
    logic [23:0] m_prev;
    logic [23:0] m_time;
    int          m_match;
    bit          m_locked;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int pat_index(input logic [6:0] p);
        for (int i = 0; i < 10; i++) if (pat[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 6; k++) m_sh[k] = 0;
        m_seen = 6'd0; m_prev = 24'd0; m_time = 24'd0; m_match = 0; m_locked = 0;
    endtask

    task automatic push_ev(input bit is_err, input logic [23:0] t);
        ev_t e;
        e.is_err = is_err;
        e.t = t;
        exp_q.push_back(e);
    endtask

    task automatic model_complete();
        int h;
        logic [23:0] f;
        int old;
        m_seen = 6'd0;
        h = m_sh[5] * 10 + m_sh[4];
        if (m_sh[5] > 2 || h > 23 || m_sh[3] > 5 || m_sh[1] > 5) begin
            push_ev(1'b1, m_time);
            for (int k = 0; k < 6; k++) m_sh[k] = 0;
            m_match = 0;
            return;
        end
        for (int k = 0; k < 6; k++) f[4*k +: 4] = 4'(m_sh[k]);
        old = m_match;
        if (f == m_prev) m_match = (old + 1 > STABLE) ? STABLE : old + 1;
        else m_match = 1;
        m_prev = f;
        if (m_match == STABLE && old < STABLE) begin
            m_time = f;
            m_locked = 1;
            push_ev(1'b0, f);
        end
    endtask

    task automatic model_sample(input int k, input logic [6:0] p);
        int v;
        v = pat_index(p);
        if (v < 0) begin
            push_ev(1'b1, m_time);
            for (int j = 0; j < 6; j++) m_sh[j] = 0;
            m_seen = 6'd0;
            m_match = 0;
            return;
        end
        m_sh[k] = v;
        m_seen[k] = 1'b1;
        if (m_seen == 6'h3f) model_complete();
    endtask

    task automatic strobe(input logic [5:0] en, input logic [6:0] p, input int hold);
        if (hold >= SETTLE + 1 && $onehot(en)) begin
            for (int k = 0; k < 6; k++) if (en[k]) model_sample(k, p);
        end
        dig_en = en;
        seg_in = p;
        repeat (hold) @(negedge clk);
        dig_en = 6'd0;
        seg_in = 7'($urandom);
        repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    function automatic logic [6:0] bad_pat();
        logic [6:0] p;
        do p = 7'($urandom); while (pat_index(p) >= 0);
        return p;
    endfunction

    function automatic int pick_hold();
        if ($urandom_range(0, 9) == 0) return $urandom_range(1, 3);
        return $urandom_range(6, 10);
    endfunction

    task automatic scan_frame(input logic [23:0] t, input int hold, input bit rnd);
        logic [6:0] p;
        logic [5:0] junk;
        int h;
        for (int k = 0; k < 6; k++) begin
            p = pat[t[4*k +: 4]];
            h = hold;
            if (rnd) begin
                if ($urandom_range(0, 19) == 0) p = bad_pat();
                h = pick_hold();
                if ($urandom_range(0, 9) == 0) begin
                    junk = 6'b000011 << $urandom_range(0, 4);
                    strobe(junk, 7'($urandom), $urandom_range(6, 9));
                end
            end
            strobe(6'(1 << k), p, h);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        dig_en = 6'd0;
        rst_n = 1'b0;
        #1;
        check("reset_time_bcd", time_bcd, 0);
        check("reset_frame_valid", frame_valid, 0);
        check("reset_code_err", code_err, 0);
        check("reset_locked", locked, 0);
        check("reset_queue_empty", exp_q.size(), 0);
        exp_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && (frame_valid || code_err)) begin
            if (frame_valid) fv_seen++;
            if (code_err) err_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_event", {frame_valid, code_err}, 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("event_is_err", code_err, e.is_err);
                check("event_frame_valid", frame_valid, !e.is_err);
                check("event_time_bcd", time_bcd, e.t);
                if (!e.is_err) check("locked_on_valid", locked, 1);
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin
        int f0, e0;
        logic [23:0] t;
        model_reset();
        #1;
        check("init_time_bcd", time_bcd, 0);
        check("init_frame_valid", frame_valid, 0);
        check("init_code_err", code_err, 0);
        check("init_locked", locked, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 12:34:56 twice
        f0 = fv_seen; e0 = err_seen;
        repeat (2) scan_frame(24'h123456, 8, 0);
        drain("drain_025");
        check("fv_count_025", fv_seen - f0, 1);
        check("time_025", time_bcd, 24'h123456);
        check("locked_025", locked, 1);

        // three of one time then two of the next
        do_reset();
        f0 = fv_seen;
        repeat (3) scan_frame(24'h123456, 8, 0);
        repeat (2) scan_frame(24'h123457, 8, 0);
        drain("drain_026");
        check("fv_count_026", fv_seen - f0, 2);
        check("time_026", time_bcd, 24'h123457);

        // out-of-range hours
        f0 = fv_seen; e0 = err_seen;
        repeat (2) scan_frame(24'h250000, 8, 0);
        drain("drain_029");
        check("err_count_029", err_seen - e0, 2);
        check("fv_count_029", fv_seen - f0, 0);
        check("time_029", time_bcd, 24'h123457);

        // blank pattern on digit 2, then two clean zero frames
        f0 = fv_seen; e0 = err_seen;
        for (int k = 0; k < 6; k++) strobe(6'(1 << k), (k == 2) ? 7'b0000000 : pat[0], 8);
        repeat (2) scan_frame(24'h000000, 8, 0);
        drain("drain_027");
        check("err_count_027", err_seen - e0, 1);
        check("fv_count_027", fv_seen - f0, 1);
        check("time_027", time_bcd, 24'h000000);

        // strobes too short to settle
        f0 = fv_seen; e0 = err_seen;
        repeat (2) scan_frame(24'h123456, 3, 0);
        drain("drain_028");
        check("fv_count_028", fv_seen - f0, 0);
        check("err_count_028", err_seen - e0, 0);
        check("time_028", time_bcd, 24'h000000);

        // reset part-way into the second identical frame
        strobe(6'b000001, 7'b0000000, 8);
        scan_frame(24'h235959, 8, 0);
        for (int k = 0; k < 4; k++) strobe(6'(1 << k), pat[4'(24'h235959 >> (4 * k))], 8);
        drain("drain_030a");
        do_reset();
        f0 = fv_seen;
        scan_frame(24'h235959, 8, 0);
        drain("drain_030b");
        check("fv_after_one_030", fv_seen - f0, 0);
        scan_frame(24'h235959, 8, 0);
        drain("drain_030c");
        check("fv_after_two_030", fv_seen - f0, 1);
        check("time_030", time_bcd, 24'h235959);

        // randomized frames with junk strobes, bad patterns and short holds
        t = 24'h000000;
        for (int i = 0; i < 30; i++) begin
            int r;
            r = $urandom_range(0, 3);
            if (r <= 1) begin
                int h, m, s;
                h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
                t = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
            end else if (r == 2) begin
                for (int k = 0; k < 6; k++) t[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            repeat ($urandom_range(1, 3)) scan_frame(t, 8, 1);
        end
        drain("drain_random");
        check("final_time_bcd", time_bcd, m_time);
        check("final_locked", locked, m_locked);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
